// File: rtl/key_irq_ctrl.sv
// ============================================================================
// Module      : key_irq_ctrl
// Description : Keypad interrupt front end for an 8088 bus. Latches one-cycle
//               debounced key events into a pending register, raises INTR,
//               answers the two-cycle INTA sequence with an 8-bit vector and
//               tracks the key in service until end-of-interrupt.
//               Optional build macro: AUTO_EOI_EN (second INTA retires the
//               interrupt immediately; eoi is ignored, in_service stays 0).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_irq_ctrl #(
  parameter int          NUM_KEYS    = 4,      // 1..7, index 7 is the spurious code
  parameter logic [7:0]  VECTOR_BASE = 8'h08   // low 3 bits must be zero
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_KEYS-1:0] key_flag,
  input  logic                inta,
  input  logic                eoi,
  input  logic                mask_wr,
  input  logic [NUM_KEYS-1:0] mask_din,
  input  logic                ovr_clr,
  output logic                intr,
  output logic [7:0]          vec_out,
  output logic                vec_oe,
  output logic [NUM_KEYS-1:0] pending,
  output logic [NUM_KEYS-1:0] in_service,
  output logic [NUM_KEYS-1:0] overrun
);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_REQ     = 2'd1;
  localparam logic [1:0] c_ST_ACK1    = 2'd2;
  localparam logic [1:0] c_ST_SERVICE = 2'd3;

  localparam logic [2:0] c_SPURIOUS   = 3'd7;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [2:0]          r_sel;
  logic [NUM_KEYS-1:0] r_mask;
  logic [NUM_KEYS-1:0] r_pending;
  logic [NUM_KEYS-1:0] r_overrun;
  logic [NUM_KEYS-1:0] r_in_service;
  logic                r_intr;
  logic [7:0]          r_vec_out;
  logic                r_vec_oe;

  logic [NUM_KEYS-1:0] w_req;
  logic                w_any_req;
  logic [2:0]          w_low_sel;
  logic [NUM_KEYS-1:0] w_sel_onehot;
  logic                w_ack2;
  logic                w_ack_real;
  logic [NUM_KEYS-1:0] w_pend_clr;

  assign w_req     = r_pending & ~r_mask;
  assign w_any_req = |w_req;

  // Lowest-index unmasked pending key; spurious code when nothing qualifies.
  always_comb begin
    w_low_sel = c_SPURIOUS;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_low_sel = 3'(i);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_sel_dec
      assign w_sel_onehot[gi] = (r_sel == 3'(gi));
    end
  endgenerate

  // The second INTA ends the acknowledge; only a real selection retires a key.
  assign w_ack2     = (r_state == c_ST_ACK1) && inta;
  assign w_ack_real = w_ack2 && (r_sel != c_SPURIOUS);
  assign w_pend_clr = w_ack_real ? w_sel_onehot : '0;

  // Next-state decode of the acknowledge sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = c_ST_REQ;
        end
      end
      c_ST_REQ: begin
        if (inta) begin
          w_state_nxt = c_ST_ACK1;
        end
      end
      c_ST_ACK1: begin
        if (inta) begin
`ifdef AUTO_EOI_EN
          w_state_nxt = c_ST_IDLE;
`else
          w_state_nxt = w_ack_real ? c_ST_SERVICE : c_ST_IDLE;
`endif
        end
      end
      c_ST_SERVICE: begin
`ifdef AUTO_EOI_EN
        w_state_nxt = c_ST_IDLE;
`else
        if (eoi) begin
          w_state_nxt = c_ST_IDLE;
        end
`endif
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // State, registered INTR and the selection frozen at the first INTA.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= c_ST_IDLE;
      r_intr  <= 1'b0;
      r_sel   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_intr  <= (w_state_nxt == c_ST_REQ);
      if ((r_state == c_ST_REQ) && inta) begin
        r_sel <= w_low_sel;
      end
    end
  end

  // Vector byte driven for exactly the cycle after the second INTA, then held.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_vec_out <= 8'd0;
      r_vec_oe  <= 1'b0;
    end else begin
      r_vec_oe <= w_ack2;
      if (w_ack2) begin
        r_vec_out <= VECTOR_BASE + {5'd0, r_sel};
      end
    end
  end

  // Pending/overrun/mask bookkeeping; a new event beats a same-cycle clear.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_pending <= '0;
      r_overrun <= '0;
      r_mask    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_pend_clr) | key_flag;
      r_overrun <= (ovr_clr ? '0 : r_overrun) | (key_flag & r_pending);
      if (mask_wr) begin
        r_mask <= mask_din;
      end
    end
  end

`ifdef AUTO_EOI_EN
  logic w_unused_eoi;
  assign w_unused_eoi = eoi;

  // Auto-EOI retires at acknowledge, so no key is ever held in service.
  always_ff @(posedge sys_clk) begin
    r_in_service <= '0;
  end
`else
  // In-service marker set by a real acknowledge, cleared by EOI.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_in_service <= '0;
    end else if (w_ack_real) begin
      r_in_service <= w_sel_onehot;
    end else if ((r_state == c_ST_SERVICE) && eoi) begin
      r_in_service <= '0;
    end
  end
`endif

  assign intr       = r_intr;
  assign vec_out    = r_vec_out;
  assign vec_oe     = r_vec_oe;
  assign pending    = r_pending;
  assign in_service = r_in_service;
  assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_key_irq_ctrl.sv
// ============================================================================
// Module      : tb_key_irq_ctrl
// Description : Self-checking bench for key_irq_ctrl: a vector table, directed
//               corner sequences and randomized traffic against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_irq_ctrl;

  localparam int         c_NK   = 4;
  localparam int         c_BASE = 8'h08;
`ifdef AUTO_EOI_EN
  localparam bit         c_AUTO = 1'b1;
`else
  localparam bit         c_AUTO = 1'b0;
`endif

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b0;
  logic [c_NK-1:0] key_flag = '0;
  logic            inta = 1'b0;
  logic            eoi = 1'b0;
  logic            mask_wr = 1'b0;
  logic [c_NK-1:0] mask_din = '0;
  logic            ovr_clr = 1'b0;
  logic            intr;
  logic [7:0]      vec_out;
  logic            vec_oe;
  logic [c_NK-1:0] pending;
  logic [c_NK-1:0] in_service;
  logic [c_NK-1:0] overrun;

  int checks = 0;
  int failures = 0;

  key_irq_ctrl #(.NUM_KEYS(c_NK), .VECTOR_BASE(8'h08)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_flag(key_flag), .inta(inta),
    .eoi(eoi), .mask_wr(mask_wr), .mask_din(mask_din), .ovr_clr(ovr_clr),
    .intr(intr), .vec_out(vec_out), .vec_oe(vec_oe), .pending(pending),
    .in_service(in_service), .overrun(overrun)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: phase 0 idle, 1 requesting, 2 between INTAs, 3 servicing.
  int              m_phase = 0;
  int              m_sel = 0;
  logic [c_NK-1:0] m_pend = '0, m_mask = '0, m_ovr = '0, m_isr = '0;
  logic [7:0]      m_vec = '0;
  logic            m_voe = 1'b0, m_intr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic [c_NK-1:0] kf, input logic ia, eo, mw,
                            input logic [c_NK-1:0] md, input logic oc, rs);
    int lowest;
    logic [c_NK-1:0] clr;
    if (rs) begin
      m_phase = 0; m_sel = 0; m_pend = '0; m_mask = '0; m_ovr = '0; m_isr = '0;
      m_vec = '0; m_voe = 1'b0; m_intr = 1'b0;
      return;
    end
    lowest = 7;
    for (int k = c_NK - 1; k >= 0; k--)
      if (m_pend[k] && !m_mask[k]) lowest = k;
    clr = '0;
    m_voe = 1'b0;
    case (m_phase)
      0: if (lowest != 7) m_phase = 1;
      1: if (ia) begin m_sel = lowest; m_phase = 2; end
      2: if (ia) begin
           m_vec = 8'(c_BASE + m_sel);
           m_voe = 1'b1;
           m_phase = 0;
           if (m_sel != 7) begin
             clr[m_sel] = 1'b1;
             if (!c_AUTO) begin m_isr = clr; m_phase = 3; end
           end
         end
      3: if (eo && !c_AUTO) begin m_isr = '0; m_phase = 0; end
      default: m_phase = 0;
    endcase
    m_ovr  = (oc ? '0 : m_ovr) | (kf & m_pend);
    m_pend = (m_pend & ~clr) | kf;
    if (mw) m_mask = md;
    m_intr = (m_phase == 1);
  endtask

  // One clock: drive, advance model at the edge, compare just after it.
  task automatic cycle(input logic [c_NK-1:0] kf, input logic ia, eo, mw,
                       input logic [c_NK-1:0] md, input logic oc, rs);
    key_flag = kf; inta = ia; eoi = eo; mask_wr = mw; mask_din = md;
    ovr_clr = oc; sys_rst = rs;
    @(posedge sys_clk);
    model_step(kf, ia, eo, mw, md, oc, rs);
    #1;
    chk("intr", intr, m_intr);
    chk("vec_oe", vec_oe, m_voe);
    chk("vec_out", vec_out, m_vec);
    chk("pending", pending, m_pend);
    chk("in_service", in_service, m_isr);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic idle();
    cycle('0, 0, 0, 0, '0, 0, 0);
  endtask

  // Unmask and retire everything outstanding, bounded.
  task automatic drain();
    int n = 0;
    cycle('0, 0, 0, 1, '0, 0, 0);
    while ((m_phase != 0 || m_pend != '0) && n < 60) begin
      cycle('0, (m_phase == 1 || m_phase == 2), (m_phase == 3), 0, '0, 0, 0);
      n++;
    end
    chk("drain_timeout", n < 60, 1);
  endtask

  typedef struct {
    logic [c_NK-1:0] kf;
    logic            ia, eo, oc;
    logic            e_intr, e_voe;
    logic [7:0]      e_vec;
    logic [c_NK-1:0] e_pend, e_isr, e_ovr;
  } vec_t;

  function automatic vec_t mk(logic [c_NK-1:0] kf, logic ia, eo, oc, e_intr, e_voe,
                              logic [7:0] e_vec, logic [c_NK-1:0] e_pend, e_isr, e_ovr);
    vec_t v;
    v.kf = kf; v.ia = ia; v.eo = eo; v.oc = oc; v.e_intr = e_intr; v.e_voe = e_voe;
    v.e_vec = e_vec; v.e_pend = e_pend; v.e_isr = e_isr; v.e_ovr = e_ovr;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    logic [c_NK-1:0] isr2;
    isr2 = c_AUTO ? 4'b0000 : 4'b0100;

    // Single key 2 served, then key 2 overrun with a single vector and ovr_clr.
    tbl[0]  = mk(4'b0100, 0, 0, 0, 0, 0, 8'h00, 4'b0100, 4'b0000, 4'b0000);
    tbl[1]  = mk(4'b0000, 0, 0, 0, 1, 0, 8'h00, 4'b0100, 4'b0000, 4'b0000);
    tbl[2]  = mk(4'b0000, 1, 0, 0, 0, 0, 8'h00, 4'b0100, 4'b0000, 4'b0000);
    tbl[3]  = mk(4'b0000, 0, 0, 0, 0, 0, 8'h00, 4'b0100, 4'b0000, 4'b0000);
    tbl[4]  = mk(4'b0000, 1, 0, 0, 0, 1, 8'h0A, 4'b0000, isr2,    4'b0000);
    tbl[5]  = mk(4'b0000, 0, 0, 0, 0, 0, 8'h0A, 4'b0000, isr2,    4'b0000);
    tbl[6]  = mk(4'b0000, 0, 1, 0, 0, 0, 8'h0A, 4'b0000, 4'b0000, 4'b0000);
    tbl[7]  = mk(4'b0000, 0, 0, 0, 0, 0, 8'h0A, 4'b0000, 4'b0000, 4'b0000);
    tbl[8]  = mk(4'b0100, 0, 0, 0, 0, 0, 8'h0A, 4'b0100, 4'b0000, 4'b0000);
    tbl[9]  = mk(4'b0100, 0, 0, 0, 1, 0, 8'h0A, 4'b0100, 4'b0000, 4'b0100);
    tbl[10] = mk(4'b0000, 1, 0, 0, 0, 0, 8'h0A, 4'b0100, 4'b0000, 4'b0100);
    tbl[11] = mk(4'b0000, 1, 0, 0, 0, 1, 8'h0A, 4'b0000, isr2,    4'b0100);
    tbl[12] = mk(4'b0000, 0, 1, 1, 0, 0, 8'h0A, 4'b0000, 4'b0000, 4'b0000);
    tbl[13] = mk(4'b0000, 0, 0, 0, 0, 0, 8'h0A, 4'b0000, 4'b0000, 4'b0000);

    // Reset state
    cycle('0, 0, 0, 0, '0, 0, 1);
    cycle('0, 0, 0, 0, '0, 0, 1);
    chk("rst_intr", intr, 0);
    chk("rst_vec_oe", vec_oe, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overrun", overrun, 0);
    idle();

    foreach (tbl[i]) begin
      cycle(tbl[i].kf, tbl[i].ia, tbl[i].eo, 0, '0, tbl[i].oc, 0);
      chk($sformatf("tbl%0d_intr", i), intr, tbl[i].e_intr);
      chk($sformatf("tbl%0d_vec_oe", i), vec_oe, tbl[i].e_voe);
      chk($sformatf("tbl%0d_vec_out", i), vec_out, tbl[i].e_vec);
      chk($sformatf("tbl%0d_pending", i), pending, tbl[i].e_pend);
      chk($sformatf("tbl%0d_in_service", i), in_service, tbl[i].e_isr);
      chk($sformatf("tbl%0d_overrun", i), overrun, tbl[i].e_ovr);
    end

    // Two keys on the same cycle: lowest first, second re-requests after EOI
    cycle(4'b1010, 0, 0, 0, '0, 0, 0);
    idle();
    chk("t2_intr", intr, 1);
    cycle('0, 1, 0, 0, '0, 0, 0);
    cycle('0, 1, 0, 0, '0, 0, 0);
    chk("t2_vec1", vec_out, 8'h09);
    chk("t2_voe1", vec_oe, 1);
    cycle('0, 0, 1, 0, '0, 0, 0);
    idle();
    chk("t2_reassert", intr, 1);
    cycle('0, 1, 0, 0, '0, 0, 0);
    cycle('0, 1, 0, 0, '0, 0, 0);
    chk("t2_vec2", vec_out, 8'h0B);
    chk("t2_isr2", in_service, c_AUTO ? 4'b0000 : 4'b1000);
    cycle('0, 0, 1, 0, '0, 0, 0);
    idle();
    chk("t2_idle_intr", intr, 0);

    // Masked key stays pending until unmasked
    cycle('0, 0, 0, 1, 4'b0001, 0, 0);
    cycle(4'b0001, 0, 0, 0, '0, 0, 0);
    idle(); idle(); idle();
    chk("t3_masked_intr", intr, 0);
    chk("t3_masked_pend", pending, 4'b0001);
    cycle('0, 0, 0, 1, 4'b0000, 0, 0);
    chk("t3_unmask_intr_early", intr, 0);
    idle();
    chk("t3_unmask_intr", intr, 1);
    drain();

    // Mask written after INTR but before first INTA yields a spurious vector
    cycle(4'b0010, 0, 0, 0, '0, 0, 0);
    idle();
    chk("t5_intr", intr, 1);
    cycle('0, 0, 0, 1, 4'b0010, 0, 0);
    cycle('0, 1, 0, 0, '0, 0, 0);
    cycle('0, 1, 0, 0, '0, 0, 0);
    chk("t5_vec", vec_out, 8'h0F);
    chk("t5_voe", vec_oe, 1);
    chk("t5_isr", in_service, 0);
    chk("t5_pend", pending, 4'b0010);
    idle(); idle();
    chk("t5_idle_intr", intr, 0);
    drain();

    // Reset during ACK1, with an INTA on the reset cycle
    cycle(4'b0001, 0, 0, 0, '0, 0, 0);
    idle();
    cycle('0, 1, 0, 0, '0, 0, 0);
    cycle('0, 1, 0, 0, '0, 0, 1);
    chk("t6_rst_intr", intr, 0);
    chk("t6_rst_pend", pending, 0);
    chk("t6_rst_voe", vec_oe, 0);
    idle();
    chk("t6_post_voe", vec_oe, 0);
    chk("t6_post_intr", intr, 0);

`ifdef AUTO_EOI_EN
    // Two keys back-to-back with no EOI
    cycle(4'b0011, 0, 0, 0, '0, 0, 0);
    idle();
    cycle('0, 1, 0, 0, '0, 0, 0);
    cycle('0, 1, 0, 0, '0, 0, 0);
    chk("auto_vec1", vec_out, 8'h08);
    idle();
    chk("auto_reassert", intr, 1);
    cycle('0, 1, 0, 0, '0, 0, 0);
    cycle('0, 1, 0, 0, '0, 0, 0);
    chk("auto_vec2", vec_out, 8'h09);
    chk("auto_isr", in_service, 0);
    chk("auto_pend", pending, 0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [c_NK-1:0] kf;
      kf = '0;
      for (int k = 0; k < c_NK; k++) kf[k] = ($urandom_range(0, 9) == 0);
      cycle(kf, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 15) == 0), c_NK'($urandom),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
